// File: rtl/ifetch_unit_if.sv
// Bundles the PC control, instruction-memory and decode-side signals of the fetch stage.
// The master modport is the fetch unit; the slave modport is its surroundings.
interface ifetch_unit_if;
    logic [31:0] pc;
    logic        pc_hold;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_fault;

    modport master (
        input  pc, flush, imem_rvalid, imem_rdata, inst_ready,
        output pc_hold, imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_fault
    );

    modport slave (
        output pc, flush, imem_rvalid, imem_rdata, inst_ready,
        input  pc_hold, imem_req, imem_addr, inst_valid, inst_out, inst_pc, fetch_fault
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding word read, a single output register for decode,
// flush/drop handling, misaligned-PC and timeout faults.
module ifetch_unit #(
    parameter int unsigned WAIT_LIMIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    ifetch_unit_if.master bus
);

    localparam logic [7:0] WaitLimit = 8'(WAIT_LIMIT);

    typedef enum logic [1:0] {StIdle, StWait, StDrop, StFault} state_e;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        fault_q, fault_d;

    logic issue_ok;
    logic misaligned;
    logic accept;
    logic req;

    // The output register is guaranteed empty or draining whenever a request goes out.
    assign issue_ok   = !bus.flush && (!inst_valid_q || bus.inst_ready);
    assign misaligned = (bus.pc[1:0] != 2'b00);
    assign accept     = (state_q == StWait) && bus.imem_rvalid && !bus.flush;
    assign req        = !rst && (state_q == StIdle) && issue_ok && !misaligned;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = req ? bus.pc : 32'h0;
    assign bus.pc_hold     = rst || !(accept || bus.flush);
    assign bus.inst_valid  = inst_valid_q;
    assign bus.inst_out    = inst_out_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.fetch_fault = fault_q;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_pc_d   = req_pc_q;
        fault_d    = fault_q;
        inst_out_d = inst_out_q;
        inst_pc_d  = inst_pc_q;

        unique case (state_q)
            StIdle: begin
                if (issue_ok) begin
                    if (misaligned) begin
                        fault_d = 1'b1;
                        state_d = StFault;
                    end else begin
                        req_pc_d   = bus.pc;
                        wait_cnt_d = 8'd0;
                        state_d    = StWait;
                    end
                end
            end
            StWait: begin
                if (bus.imem_rvalid) begin
                    state_d = StIdle;
                end else if (bus.flush) begin
                    state_d = StDrop;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == WaitLimit) begin
                        fault_d = 1'b1;
                        state_d = StFault;
                    end
                end
            end
            StDrop: begin
                // The single outstanding response is consumed here even if flush repeats.
                if (bus.imem_rvalid) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                if (bus.flush) begin
                    fault_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            inst_out_d = bus.imem_rdata;
            inst_pc_d  = req_pc_q;
        end

        if (bus.flush) begin
            inst_valid_d = 1'b0;
        end else if (accept) begin
            inst_valid_d = 1'b1;
        end else if (inst_valid_q && bus.inst_ready) begin
            inst_valid_d = 1'b0;
        end else begin
            inst_valid_d = inst_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wait_cnt_q   <= 8'd0;
            req_pc_q     <= 32'h0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= 32'h0;
            inst_pc_q    <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            req_pc_q     <= req_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic, checked cycle by cycle
// against a transaction-level model of the fetch stage and a variable-latency memory.
module tb_ifetch_unit;

    localparam int WaitLimit = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifetch_unit_if bus ();

    ifetch_unit #(.WAIT_LIMIT(WaitLimit)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Memory environment
    int          lat = 1;
    logic [31:0] fixed_data = 32'h0;
    logic        mem_pend = 1'b0;
    int          mem_due = 0;
    logic [31:0] mem_data = 32'h0;

    // Reference model: outstanding/discard/fault flags plus the held instruction
    logic        m_busy = 1'b0;
    logic        m_drop = 1'b0;
    logic        m_fault = 1'b0;
    int          m_waited = 0;
    logic [31:0] m_req_pc = 32'h0;
    logic        m_have = 1'b0;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_ipc = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] p, input logic f, input logic rdy);
        logic        rv;
        logic        exp_issue;
        logic        exp_accept;
        logic        exp_hold;
        logic        had;
        logic [31:0] rd;
        @(negedge clk);
        rv = !r && mem_pend && (mem_due == cyc);
        rd = rv ? mem_data : $urandom;
        rst             = r;
        bus.pc          = p;
        bus.flush       = f;
        bus.inst_ready  = rdy;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        #1;
        exp_issue  = !r && !m_busy && !m_drop && !m_fault && !f && (!m_have || rdy)
                     && (p[1:0] == 2'b00);
        exp_accept = !r && m_busy && rv && !f;
        exp_hold   = r || !(exp_accept || f);
        check_eq("imem_req", 32'(bus.imem_req), 32'(exp_issue));
        check_eq("imem_addr", bus.imem_addr, exp_issue ? p : 32'h0);
        check_eq("pc_hold", 32'(bus.pc_hold), 32'(exp_hold));
        check_eq("inst_valid", 32'(bus.inst_valid), 32'(m_have));
        check_eq("inst_out", bus.inst_out, m_inst);
        check_eq("inst_pc", bus.inst_pc, m_ipc);
        check_eq("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));

        if (r || rv) mem_pend = 1'b0;
        if (!r && bus.imem_req) begin
            mem_pend = 1'b1;
            mem_due  = cyc + lat;
            mem_data = (fixed_data != 32'h0) ? fixed_data : $urandom;
        end

        if (r) begin
            m_busy = 0; m_drop = 0; m_fault = 0; m_waited = 0; m_req_pc = 0;
            m_have = 0; m_inst = 0; m_ipc = 0;
        end else begin
            had = m_have;
            if (f) m_have = 0;
            else if (exp_accept) begin
                m_have = 1; m_inst = rd; m_ipc = m_req_pc;
            end else if (m_have && rdy) m_have = 0;

            if (m_busy) begin
                if (rv) m_busy = 0;
                else if (f) begin
                    m_busy = 0; m_drop = 1;
                end else begin
                    m_waited++;
                    if (m_waited == WaitLimit) begin
                        m_busy = 0; m_fault = 1;
                    end
                end
            end else if (m_drop) begin
                if (rv) m_drop = 0;
            end else if (m_fault) begin
                if (f) m_fault = 0;
            end else if (!f && (!had || rdy)) begin
                if (p[1:0] != 2'b00) m_fault = 1;
                else begin
                    m_busy = 1; m_waited = 0; m_req_pc = p;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] p;
        logic        f;
        logic        r;
        bus.pc = 32'h0; bus.flush = 1'b0; bus.inst_ready = 1'b0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;

        // Basic fetch with 1-cycle memory
        lat = 1; fixed_data = 32'h2008_0005;
        step(1'b1, 32'h0040_0000, 1'b0, 1'b1);
        step(1'b1, 32'h0040_0000, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0040_0000, 1'b0, 1'b1);

        // Backpressure, then release
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0040_0004, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0040_0004, 1'b0, 1'b1);
        fixed_data = 32'h0;

        // Flush while waiting on a 4-cycle memory
        lat = 4;
        step(1'b1, 32'h0040_0000, 1'b0, 1'b1);
        step(1'b0, 32'h0040_0008, 1'b0, 1'b1);
        step(1'b0, 32'h0040_0008, 1'b0, 1'b1);
        step(1'b0, 32'h0040_0100, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0040_0100, 1'b0, 1'b1);

        // Flush coinciding with the response
        lat = 2;
        step(1'b1, 32'h0040_0000, 1'b0, 1'b1);
        step(1'b0, 32'h0040_0010, 1'b0, 1'b1);
        step(1'b0, 32'h0040_0010, 1'b0, 1'b1);
        step(1'b0, 32'h0040_0200, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0040_0200, 1'b0, 1'b1);

        // Misaligned PC, sticky fault, cleared by flush
        lat = 1;
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0040_0002, 1'b0, 1'b1);
        step(1'b0, 32'h0040_0300, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0040_0300, 1'b0, 1'b1);

        // Timeout with a late stray response arriving in FAULT
        lat = WaitLimit + 3;
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0040_0400, 1'b0, 1'b1);
        step(1'b0, 32'h0040_0500, 1'b1, 1'b1);
        lat = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0040_0500, 1'b0, 1'b1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            lat = ($urandom_range(0, 19) == 0) ? WaitLimit + 3 : int'($urandom_range(1, 4));
            p = 32'h0040_0000 | ({$urandom} & 32'h0000_0ffc);
            if ($urandom_range(0, 15) == 0) p[1:0] = 2'($urandom_range(1, 3));
            f = ($urandom_range(0, 9) == 0);
            if (m_fault && mem_pend) f = 1'b0;
            if (m_fault && !mem_pend && $urandom_range(0, 3) == 0) f = 1'b1;
            r = ($urandom_range(0, 199) == 0);
            step(r, p, f, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
